// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, arbiter FSM encoding and opcode legality check.
package alu_pkg;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      AluAnd, AluOr, AluAdd, AluSub, AluSlt, AluNor: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... (mod N_REQ) for the first request.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    logic              found;
    int unsigned       cand;
    logic [ID_W-1:0]   cand_idx;
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(ptr) + k) % N_REQ;
      cand_idx = cand[ID_W-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between N_REQ requesters, tagged response channel.
// Define ALU_ARB_OPCHECK_EN to flag illegal opcodes via rsp_err (op executes as a zeroed ADD).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  input  logic [4*N_REQ-1:0]    req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_zero,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_err
);

  state_e           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  pend_id;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [3:0]       sel_op;
  logic [3:0]       sel_ctrl;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = (state == StIdle) ? grant : '0;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*32 +: 32];
        sel_b  = req_b[i*32 +: 32];
        sel_op = req_op[i*4 +: 4];
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic sel_legal;
  logic pend_err;

  assign sel_legal = op_is_legal(sel_op);
  // Illegal codes still run through the ALU, but as a harmless ADD whose result is discarded.
  assign sel_ctrl  = sel_legal ? sel_op : AluAdd;
`else
  assign sel_ctrl = sel_op;
  assign rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      rr_ptr    <= ID_W'(N_REQ - 1);
      pend_id   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= AluAdd;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_id    <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      pend_err  <= 1'b0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (|req_valid) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_ctrl <= sel_ctrl;
            pend_id  <= grant_idx;
            rr_ptr   <= grant_idx;
`ifdef ALU_ARB_OPCHECK_EN
            pend_err <= ~sel_legal;
`endif
            state    <= StExec;
          end
        end
        StExec: begin
`ifdef ALU_ARB_OPCHECK_EN
          rsp_data <= pend_err ? 32'd0 : alu_result;
          rsp_zero <= pend_err ? 1'b0 : alu_zero;
          rsp_err  <= pend_err;
`else
          rsp_data <= alu_result;
          rsp_zero <= alu_zero;
`endif
          rsp_id    <= pend_id;
          rsp_valid <= 1'b1;
          state     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
